seq_playback_ctrl: RTL and testbench
====================================

Name: seq_playback_ctrl

Overview:
Playback controller for the sequence ROM and taglist RAM. It turns the up/down pushbuttons into a wrapped sequence number and reads that sequence's start address from the taglist RAM. It then steps the ROM address once per playback tick, looping or halting on end markers. Everything runs on CLK_50; the playback rate comes from a one-cycle tick enable, not a second clock.

Parameters:
ADDR_W, 10, ROM address width
SEQ_W, 6, sequence number / taglist RAM address width
NUM_SEQ, 64, number of valid sequences; seq_num wraps within 0..NUM_SEQ-1 (2..2^SEQ_W)
DEBOUNCE_CYC, 16, consecutive stable cycles before a synchronized button level is accepted (>=2)

Ports:
CLK_50  in  1  system clock; all logic on its rising edge
reset  in  1  synchronous, active-high
pb_seq_up  in  1  raw pushbutton, asynchronous, active-high
pb_seq_dn  in  1  raw pushbutton, asynchronous, active-high
step_tick  in  1  one-cycle playback-rate strobe
tag_rd_addr  out  SEQ_W  taglist RAM read address, registered, always equals seq_num
tag_rd_data  in  ADDR_W  start ROM address of the sequence; valid 1 cycle after tag_rd_addr
rom_addr  out  ADDR_W  ROM read address, registered
rom_end  in  2  ROM word bits [1:0] for rom_addr; valid from the 2nd cycle after rom_addr changes
seq_num  out  SEQ_W  current sequence number
playing  out  1  high while stepping (SETTLE/PLAY)
seq_changed  out  1  one-cycle pulse when seq_num updates

Behaviour:
- Reset: seq_num=0, tag_rd_addr=0, rom_addr=0, start_addr=0, playing=0, seq_changed=0, debounce counters and levels=0, state=LOAD. Seq 0 auto-loads after reset release.
- Button path, per button:
  - 2-flop synchronizer.
  - Debounced level updates only after the synchronized value differs from it for DEBOUNCE_CYC consecutive cycles; any bounce restarts the count.
  - A request is a 0->1 edge of the debounced level, one per press however long held.
- Requests:
  - up only: seq_num+1; NUM_SEQ-1 wraps to 0.
  - dn only: seq_num-1; 0 wraps to NUM_SEQ-1.
  - up and dn in the same cycle: both dropped, no change.
  - On an accepted request: seq_num and tag_rd_addr update next edge, seq_changed pulses 1 cycle, state->LOAD from any state, including mid-load (load restarts).
- FSM (states LOAD, CAPT, SETTLE, PLAY, HALT):
  - LOAD: tag_rd_addr stable; ->CAPT next cycle.
  - CAPT: start_addr<=tag_rd_data, rom_addr<=tag_rd_data; ->SETTLE.
  - SETTLE: 1 cycle covering ROM latency; ->PLAY.
  - PLAY, on step_tick:
    - rom_end==2'b11 (loop): rom_addr<=start_addr; ->SETTLE.
    - rom_end==2'b01 (halt): rom_addr held; ->HALT.
    - 00 or 10: rom_addr<=rom_addr+1, modulo 2^ADDR_W (1023->0); ->SETTLE.
  - HALT: playing=0; left only via a button request or reset.
- step_tick outside PLAY is dropped, not queued. A tick coinciding with a button request is dropped; the request wins.
- playing=1 in SETTLE and PLAY, 0 in LOAD, CAPT, HALT.
- Latency:
  - Button press to seq_changed: 2 sync + DEBOUNCE_CYC + 1 cycles.
  - seq_changed to new rom_addr: 2 cycles.
  - step_tick to rom_addr change: 1 cycle.
- Reset asserted in any state overrides everything on that edge.

Test Plan:
- Reset release, tag_rd_data=0x040 for seq 0 -> tag_rd_addr=0; rom_addr=0x040 two cycles later; playing=1 from SETTLE.
- DEBOUNCE_CYC=4. Press up with 3 bounces of 2 cycles, then hold 50 cycles -> exactly one seq_changed; seq_num 0->1; rom_addr reloads to slot-1 value 0x100.
- seq_num=0, press dn -> seq_num=63 (NUM_SEQ=64). Then press up -> seq_num=0.
- PLAY from 0x100, rom_end=00 at 0x100..0x102, 11 at 0x103, ticks every 10 cycles -> rom_addr 0x101, 0x102, 0x103, 0x100, 0x101.
- rom_end=01 at 0x105 -> state HALT, playing=0, rom_addr stays 0x105 over 20 ticks. Then a dn press -> reload, playing=1.
- Up and dn debounced edges on the same cycle -> no seq_changed, seq_num unchanged. Separately: up press during CAPT -> load restarts, rom_addr ends at the new seq's start.

Source files
------------

// File: rtl/seq_playback_ctrl_if.sv
// Memory-side bus of the playback controller: taglist RAM read port and sequence ROM read port.
interface seq_playback_ctrl_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned SEQ_W  = 6
);
  logic [SEQ_W-1:0]  tag_rd_addr;
  logic [ADDR_W-1:0] tag_rd_data;
  logic [ADDR_W-1:0] rom_addr;
  logic [1:0]        rom_end;

  modport master (output tag_rd_addr, output rom_addr, input tag_rd_data, input rom_end);
  modport slave  (input tag_rd_addr, input rom_addr, output tag_rd_data, output rom_end);
endinterface

// File: rtl/seq_playback_ctrl.sv
// Sequence playback controller: debounced up/down buttons select a sequence,
// its start address is fetched from the taglist RAM and the ROM is stepped per tick.
module seq_playback_ctrl #(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned SEQ_W        = 6,
  parameter int unsigned NUM_SEQ      = 64,
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic                 CLK_50,
  input  logic                 reset,
  input  logic                 pb_seq_up,
  input  logic                 pb_seq_dn,
  input  logic                 step_tick,
  seq_playback_ctrl_if.master  mem,
  output logic [SEQ_W-1:0]     seq_num,
  output logic                 playing,
  output logic                 seq_changed
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);

  typedef enum logic [2:0] {ST_LOAD, ST_CAPT, ST_SETTLE, ST_PLAY, ST_HALT} state_e;

  state_e                   state_q, state_d;
  logic [1:0]               sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]               lvl_q, lvl_d, lvl_prev_q, lvl_prev_d;
  logic [1:0][CNT_W-1:0]    cnt_q, cnt_d;
  logic [SEQ_W-1:0]         seq_q, seq_d, tag_addr_q, tag_addr_d;
  logic [ADDR_W-1:0]        rom_addr_q, rom_addr_d, start_q, start_d;
  logic                     playing_q, playing_d, changed_q, changed_d;
  logic [1:0]               req;
  logic                     accept;

  // Per-button synchronizer and debouncer; bit 0 = up, bit 1 = down.
  always_comb begin
    sync1_d    = {pb_seq_dn, pb_seq_up};
    sync2_d    = sync1_q;
    lvl_d      = lvl_q;
    cnt_d      = cnt_q;
    lvl_prev_d = lvl_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYC - 1)) begin
          lvl_d[i] = sync2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
    req = lvl_q & ~lvl_prev_q;
  end

  assign accept = req[0] ^ req[1];

  // Sequence selection and playback FSM; a button request overrides any state and any tick.
  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    tag_addr_d = tag_addr_q;
    rom_addr_d = rom_addr_q;
    start_d    = start_q;
    changed_d  = 1'b0;
    if (accept) begin
      if (req[0]) begin
        seq_d = (seq_q == SEQ_W'(NUM_SEQ - 1)) ? '0 : seq_q + SEQ_W'(1);
      end else begin
        seq_d = (seq_q == '0) ? SEQ_W'(NUM_SEQ - 1) : seq_q - SEQ_W'(1);
      end
      tag_addr_d = seq_d;
      changed_d  = 1'b1;
      state_d    = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD:   state_d = ST_CAPT;
        ST_CAPT: begin
          start_d    = mem.tag_rd_data;
          rom_addr_d = mem.tag_rd_data;
          state_d    = ST_SETTLE;
        end
        ST_SETTLE: state_d = ST_PLAY;
        ST_PLAY: begin
          if (step_tick) begin
            case (mem.rom_end)
              2'b11: begin
                rom_addr_d = start_q;
                state_d    = ST_SETTLE;
              end
              2'b01:   state_d = ST_HALT;
              default: begin
                rom_addr_d = rom_addr_q + ADDR_W'(1);
                state_d    = ST_SETTLE;
              end
            endcase
          end
        end
        ST_HALT:   state_d = ST_HALT;
        default:   state_d = ST_LOAD;
      endcase
    end
    playing_d = (state_d == ST_SETTLE) || (state_d == ST_PLAY);
  end

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      state_q    <= ST_LOAD;
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
      cnt_q      <= '0;
      seq_q      <= '0;
      tag_addr_q <= '0;
      rom_addr_q <= '0;
      start_q    <= '0;
      playing_q  <= 1'b0;
      changed_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_prev_d;
      cnt_q      <= cnt_d;
      seq_q      <= seq_d;
      tag_addr_q <= tag_addr_d;
      rom_addr_q <= rom_addr_d;
      start_q    <= start_d;
      playing_q  <= playing_d;
      changed_q  <= changed_d;
    end
  end

  assign mem.tag_rd_addr = tag_addr_q;
  assign mem.rom_addr    = rom_addr_q;
  assign seq_num         = seq_q;
  assign playing         = playing_q;
  assign seq_changed     = changed_q;

endmodule

// File: tb/tb_seq_playback_ctrl.sv
// Directed bench for seq_playback_ctrl with behavioural taglist RAM and sequence ROM.
module tb_seq_playback_ctrl;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned SEQ_W  = 6;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             pb_up = 1'b0;
  logic             pb_dn = 1'b0;
  logic             step_tick = 1'b0;
  logic [SEQ_W-1:0] seq_num;
  logic             playing;
  logic             seq_changed;
  logic             loop_en = 1'b0;
  int               errs = 0;
  int               checks = 0;
  int               chg_cnt = 0;
  int               chg_base;

  seq_playback_ctrl_if #(.ADDR_W(ADDR_W), .SEQ_W(SEQ_W)) bus ();

  seq_playback_ctrl #(
    .ADDR_W(ADDR_W), .SEQ_W(SEQ_W), .NUM_SEQ(64), .DEBOUNCE_CYC(4)
  ) dut (
    .CLK_50(clk), .reset(reset), .pb_seq_up(pb_up), .pb_seq_dn(pb_dn),
    .step_tick(step_tick), .mem(bus.master), .seq_num(seq_num),
    .playing(playing), .seq_changed(seq_changed)
  );

  always #5 clk = ~clk;

  function automatic logic [ADDR_W-1:0] tag_of(input logic [SEQ_W-1:0] a);
    if (a == '0) return 10'h040;
    return 10'({4'b0, a} * 10'd16 + 10'h0F0);
  endfunction

  function automatic logic [1:0] rom_of(input logic [ADDR_W-1:0] a, input logic lp);
    if (a == 10'h103 && lp) return 2'b11;
    if (a == 10'h105) return 2'b01;
    return 2'b00;
  endfunction

  // One-cycle registered reads on both memories
  always @(posedge clk) begin
    bus.tag_rd_data <= tag_of(bus.tag_rd_addr);
    bus.rom_end     <= rom_of(bus.rom_addr, loop_en);
  end

  always @(negedge clk) if (seq_changed) chg_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic up, input logic dn, input int bounces, input int hold);
    for (int b = 0; b < bounces; b++) begin
      @(negedge clk); pb_up = up; pb_dn = dn;
      repeat (2) @(negedge clk);
      pb_up = 1'b0; pb_dn = 1'b0;
      repeat (1) @(negedge clk);
    end
    @(negedge clk); pb_up = up; pb_dn = dn;
    repeat (hold) @(negedge clk);
    pb_up = 1'b0; pb_dn = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic tick(input logic chk, input logic [ADDR_W-1:0] exp);
    @(negedge clk); step_tick = 1'b1;
    @(negedge clk); step_tick = 1'b0;
    if (chk) check_eq("tick_rom_addr", 32'(bus.rom_addr), 32'(exp));
    repeat (8) @(negedge clk);
  endtask

  initial begin
    logic [ADDR_W-1:0] loop_seq [5];
    logic [ADDR_W-1:0] run_seq [4];
    loop_seq = '{10'h101, 10'h102, 10'h103, 10'h100, 10'h101};
    run_seq  = '{10'h102, 10'h103, 10'h104, 10'h105};

    repeat (3) @(negedge clk);
    check_eq("rst_seq_num", 32'(seq_num), 32'd0);
    check_eq("rst_tag_addr", 32'(bus.tag_rd_addr), 32'd0);
    check_eq("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    check_eq("rst_playing", 32'(playing), 32'd0);
    check_eq("rst_changed", 32'(seq_changed), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("capt_playing", 32'(playing), 32'd0);
    @(negedge clk);
    check_eq("boot_rom_addr", 32'(bus.rom_addr), 32'h040);
    check_eq("boot_playing", 32'(playing), 32'd1);

    // Bouncy up press: exactly one request
    chg_base = chg_cnt;
    press(1'b1, 1'b0, 3, 50);
    check_eq("bounce_changes", 32'(chg_cnt - chg_base), 32'd1);
    check_eq("up_seq_num", 32'(seq_num), 32'd1);
    check_eq("up_tag_addr", 32'(bus.tag_rd_addr), 32'd1);
    check_eq("up_rom_addr", 32'(bus.rom_addr), 32'h100);
    check_eq("up_playing", 32'(playing), 32'd1);

    // Stepping with a loop marker at 0x103
    loop_en = 1'b1;
    foreach (loop_seq[i]) tick(1'b1, loop_seq[i]);
    loop_en = 1'b0;
    foreach (run_seq[i]) tick(1'b1, run_seq[i]);
    tick(1'b1, 10'h105);
    check_eq("halt_playing", 32'(playing), 32'd0);
    for (int i = 0; i < 20; i++) tick(1'b0, 10'h0);
    check_eq("halt_rom_addr", 32'(bus.rom_addr), 32'h105);
    check_eq("halt_playing_held", 32'(playing), 32'd0);

    // Down press leaves HALT and reloads
    chg_base = chg_cnt;
    press(1'b0, 1'b1, 0, 20);
    check_eq("dn_changes", 32'(chg_cnt - chg_base), 32'd1);
    check_eq("dn_seq_num", 32'(seq_num), 32'd0);
    check_eq("dn_rom_addr", 32'(bus.rom_addr), 32'h040);
    check_eq("dn_playing", 32'(playing), 32'd1);

    // Wrap both ways
    press(1'b0, 1'b1, 0, 20);
    check_eq("wrap_dn_seq", 32'(seq_num), 32'd63);
    check_eq("wrap_dn_tag", 32'(bus.tag_rd_addr), 32'd63);
    check_eq("wrap_dn_rom", 32'(bus.rom_addr), 32'(tag_of(6'd63)));
    press(1'b1, 1'b0, 0, 20);
    check_eq("wrap_up_seq", 32'(seq_num), 32'd0);
    check_eq("wrap_up_rom", 32'(bus.rom_addr), 32'h040);

    // Simultaneous up and down are both dropped
    chg_base = chg_cnt;
    press(1'b1, 1'b1, 0, 20);
    check_eq("both_changes", 32'(chg_cnt - chg_base), 32'd0);
    check_eq("both_seq_num", 32'(seq_num), 32'd0);

    // Up request lands while the dn-triggered load is in CAPT
    chg_base = chg_cnt;
    @(negedge clk); pb_dn = 1'b1;
    repeat (2) @(negedge clk);
    pb_up = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("restart_first_seq", 32'(seq_num), 32'd63);
    repeat (2) @(negedge clk);
    check_eq("restart_seq_num", 32'(seq_num), 32'd0);
    check_eq("restart_changed", 32'(seq_changed), 32'd1);
    check_eq("restart_playing", 32'(playing), 32'd0);
    pb_up = 1'b0; pb_dn = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("restart_changes", 32'(chg_cnt - chg_base), 32'd2);
    check_eq("restart_rom_addr", 32'(bus.rom_addr), 32'h040);
    check_eq("restart_play_end", 32'(playing), 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
